// File: rtl/sega_pad_emulator.sv
// sega_pad_emulator: Megadrive 6-button pad as seen from the DB9 connector.
// Drives the six DB9 data pins from a negative-logic MXYZ SACB RLDU button
// word, multiplexed by the pad select line (pin 7).
//
// Build option: define SEGA_PAD_6BTN_EN to get the full 6-button phase
// sequence with its inactivity timeout. Without it the block is a plain
// 3-button pad and phase_o reads 0.
module sega_pad_emulator #(
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        select_i,
  input  logic [11:0] buttons_n_i,
  output logic [5:0]  db9_o,
  output logic [2:0]  phase_o
);

  // buttons_n_i layout: [11]M [10]X [9]Y [8]Z [7]S [6]A [5]C [4]B [3]R [2]L [1]D [0]U
  // db9_o layout:       [5]p9 [4]p6 [3]right [2]left [1]down [0]up

  logic       sync1_q;
  logic       sel_s_q;
  logic [5:0] db9_q;
  logic [5:0] db9_d;

  // Two-flop synchroniser for the asynchronous select line
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sel_s_q <= 1'b1;
    end else begin
      sync1_q <= select_i;
      sel_s_q <= sync1_q;
    end
  end

  // Registered DB9 data pins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db9_q <= 6'b111111;
    end else begin
      db9_q <= db9_d;
    end
  end

  assign db9_o = db9_q;

`ifdef SEGA_PAD_6BTN_EN

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4
  } phase_e;

  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  phase_e        p_q;
  phase_e        p_d;
  logic          sel_prev_q;
  logic [TW-1:0] to_cnt_q;
  logic [TW-1:0] to_cnt_d;
  logic          fall;
  logic          rise;
  logic          to_hit;

  // Phase state, previous select level and inactivity timer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_q        <= PH0;
      sel_prev_q <= 1'b1;
      to_cnt_q   <= '0;
    end else begin
      p_q        <= p_d;
      sel_prev_q <= sel_s_q;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Edge detection, inactivity timer and phase sequencing; a falling edge
  // takes priority over a timeout expiring in the same cycle
  always_comb begin
    fall     = sel_prev_q & ~sel_s_q;
    rise     = ~sel_prev_q & sel_s_q;
    to_hit   = (to_cnt_q == TO_MAX);
    to_cnt_d = to_cnt_q;
    p_d      = p_q;

    if (fall || rise) begin
      to_cnt_d = '0;
    end else if (!to_hit) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    if (fall) begin
      case (p_q)
        PH0:     p_d = PH1;
        PH1:     p_d = PH2;
        PH2:     p_d = PH3;
        default: p_d = PH4;
      endcase
    end else if (rise && (p_q == PH4)) begin
      p_d = PH0;
    end else if (to_hit) begin
      p_d = PH0;
    end
  end

  // Pad data mux; it looks at the phase being entered so that db9_o and
  // phase_o change on the same clock
  always_comb begin
    db9_d = buttons_n_i[5:0];
    if (sel_s_q) begin
      if (p_d == PH3) begin
        db9_d = {buttons_n_i[5:4], buttons_n_i[11:8]};
      end
    end else begin
      case (p_d)
        PH3:     db9_d = {buttons_n_i[7:6], 4'b0000};
        PH4:     db9_d = {buttons_n_i[7:6], 4'b1111};
        default: db9_d = {buttons_n_i[7:6], 2'b00, buttons_n_i[1:0]};
      endcase
    end
  end

  assign phase_o = p_q;

`else

  // The timeout and the extra buttons have no meaning on a 3-button pad
  logic [TW-1:0] unused_tw;
  logic [3:0]    unused_mxyz;

  assign unused_tw   = TW'(TIMEOUT_CYCLES);
  assign unused_mxyz = buttons_n_i[11:8];

  // 3-button data mux: C/B/directions with select high, S/A/up/down low
  always_comb begin
    db9_d = buttons_n_i[5:0];
    if (!sel_s_q) begin
      db9_d = {buttons_n_i[7:6], 2'b00, buttons_n_i[1:0]};
    end
  end

  assign phase_o = 3'd0;

`endif

endmodule

// File: tb/tb_sega_pad_emulator.sv
// Testbench for sega_pad_emulator. Stimulus pushes expected DB9/phase values
// tagged with the cycle they are due; a monitor pops and compares them.
// Expected tables follow the SEGA_PAD_6BTN_EN build option.
module tb_sega_pad_emulator;

  localparam int TO = 200;

`ifdef SEGA_PAD_6BTN_EN
  localparam logic [2:0] P1 = 3'd1;
  localparam logic [5:0] ID_LO  [4] = '{6'b110011, 6'b110011, 6'b110000, 6'b111111};
  localparam logic [5:0] ID_HI  [4] = '{6'b111111, 6'b111111, 6'b111110, 6'b111111};
  localparam logic [2:0] ID_PLO [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  localparam logic [2:0] ID_PHI [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
  localparam logic [5:0] TG_HI  [4] = '{6'b111111, 6'b111111, 6'b110111, 6'b111111};
  localparam logic [2:0] TO_PH  [3] = '{3'd1, 3'd2, 3'd1};
`else
  localparam logic [2:0] P1 = 3'd0;
  localparam logic [5:0] ID_LO  [4] = '{6'b110011, 6'b110011, 6'b110011, 6'b110011};
  localparam logic [5:0] ID_HI  [4] = '{6'b111111, 6'b111111, 6'b111111, 6'b111111};
  localparam logic [2:0] ID_PLO [4] = '{3'd0, 3'd0, 3'd0, 3'd0};
  localparam logic [2:0] ID_PHI [4] = '{3'd0, 3'd0, 3'd0, 3'd0};
  localparam logic [5:0] TG_HI  [4] = '{6'b111111, 6'b111111, 6'b111111, 6'b111111};
  localparam logic [2:0] TO_PH  [3] = '{3'd0, 3'd0, 3'd0};
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        select_i;
  logic [11:0] buttons_n_i;
  logic [5:0]  db9_o;
  logic [2:0]  phase_o;

  int cyc      = 0;
  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int         cyc;
    logic [5:0] db9;
    logic [2:0] ph;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  exp_t  m_e;
  string m_nm;

  sega_pad_emulator #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .select_i   (select_i),
    .buttons_n_i(buttons_n_i),
    .db9_o      (db9_o),
    .phase_o    (phase_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int dly, input logic [5:0] d, input logic [2:0] ph,
                           input string nm);
    exp_t e;
    e.cyc = cyc + dly;
    e.db9 = d;
    e.ph  = ph;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    expect_at(1, 6'b111111, 3'd0, "rst");
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic pulse(input int lo, input int hi, input logic [5:0] dl, input logic [2:0] pl,
                       input logic [5:0] dh, input logic [2:0] ph, input string nm);
    select_i = 1'b0;
    expect_at(3, dl, pl, {nm, "_lo"});
    wait_clk(lo);
    select_i = 1'b1;
    expect_at(3, dh, ph, {nm, "_hi"});
    wait_clk(hi);
  endtask

  // Monitor: compare every expectation that falls due on this cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      m_e  = exp_q.pop_front();
      m_nm = nm_q.pop_front();
      n_checks++;
      if (m_e.cyc != cyc) begin
        n_err++;
        $display("FAIL %s: slot for cycle %0d missed, now cycle %0d", m_nm, m_e.cyc, cyc);
      end else if (db9_o !== m_e.db9) begin
        n_err++;
        $display("FAIL %s db9: got %b expected %b at cycle %0d", m_nm, db9_o, m_e.db9, cyc);
      end
      n_checks++;
      if (phase_o !== m_e.ph) begin
        n_err++;
        $display("FAIL %s phase: got %0d expected %0d at cycle %0d", m_nm, phase_o, m_e.ph, cyc);
      end
    end
  end

  initial begin
    // Reset held for 4 clocks with every button pressed
    reset_n     = 1'b0;
    select_i    = 1'b1;
    buttons_n_i = 12'h000;
    for (int i = 1; i <= 4; i++) expect_at(i, 6'b111111, 3'd0, "reset_hold");
    wait_clk(4);
    reset_n = 1'b1;
    expect_at(3, 6'b000000, 3'd0, "reset_release");
    wait_clk(6);

    // 3-button read with A pressed, including the 3-clock latency
    buttons_n_i = 12'hFBF;
    expect_at(3, 6'b111111, 3'd0, "idle_a");
    wait_clk(4);
    select_i = 1'b0;
    expect_at(2, 6'b111111, 3'd0, "fall_pre");
    expect_at(3, 6'b100011, P1, "fall_edge");
    expect_at(10, 6'b100011, P1, "fall_hold");
    wait_clk(20);
    select_i = 1'b1;
    expect_at(2, 6'b100011, P1, "rise_pre");
    expect_at(3, 6'b111111, P1, "rise_edge");
    wait_clk(20);

    // Live button change shows up one clock later
    buttons_n_i = 12'hFFE;
    expect_at(1, 6'b111110, P1, "live_up");
    wait_clk(3);
    buttons_n_i = 12'hFFF;
    expect_at(1, 6'b111111, P1, "live_rel");
    wait_clk(3);

    // 6-button identification sequence with Z pressed
    do_reset();
    buttons_n_i = 12'hEFF;
    for (int k = 0; k < 4; k++) pulse(20, 20, ID_LO[k], ID_PLO[k], ID_HI[k], ID_PHI[k], "id");

    // Inactivity timeout returns the phase to 0
    do_reset();
    buttons_n_i = 12'hEFF;
    pulse(20, 20, 6'b110011, TO_PH[0], 6'b111111, TO_PH[0], "to1");
    pulse(20, 20, 6'b110011, TO_PH[1], 6'b111111, TO_PH[1], "to2");
    expect_at(TO + 2, 6'b111111, 3'd0, "to_expired");
    wait_clk(TO + 2);
    pulse(20, 20, 6'b110011, TO_PH[2], 6'b111111, TO_PH[2], "to_after");

    // Continuous toggling with M pressed
    do_reset();
    buttons_n_i = 12'h7FF;
    for (int j = 0; j < 40; j++)
      pulse(32, 32, ID_LO[j % 4], ID_PLO[j % 4], TG_HI[j % 4], ID_PHI[j % 4], "tog");

    // Reset while in phase 3 with select low, then resume with select low
    do_reset();
    buttons_n_i = 12'hEFF;
    pulse(20, 20, ID_LO[0], ID_PLO[0], ID_HI[0], ID_PHI[0], "mid1");
    pulse(20, 20, ID_LO[1], ID_PLO[1], ID_HI[1], ID_PHI[1], "mid2");
    select_i = 1'b0;
    expect_at(3, ID_LO[2], ID_PLO[2], "mid_lo");
    wait_clk(10);
    reset_n = 1'b0;
    expect_at(1, 6'b111111, 3'd0, "mid_reset");
    wait_clk(2);
    reset_n = 1'b1;
    expect_at(3, 6'b110011, P1, "mid_resume");
    wait_clk(10);
    select_i = 1'b1;
    wait_clk(10);

    // Let outstanding expectations drain, bounded
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) wait_clk(1);
    while (exp_q.size() > 0) begin
      m_e  = exp_q.pop_front();
      m_nm = nm_q.pop_front();
      n_checks++;
      n_err++;
      $display("FAIL %s: never compared, due at cycle %0d, now %0d", m_nm, m_e.cyc, cyc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
